// File: rtl/fifo_8_to_32_byte_packer.sv
// Byte-to-word packer for the SiTCP RX stream: collects three little-endian bytes
// and flags the fourth as completing a 32-bit word.
module byte_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        write_i,
  input  logic [7:0]  data_i,
  output logic        word_valid_o,
  output logic [31:0] word_data_o,
  output logic [1:0]  index_d_o
);

  localparam int         LANE_W    = 8;
  localparam logic [1:0] LAST_LANE = 2'd3;

  logic [1:0]  index_q, index_d;
  logic [23:0] partial_q, partial_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    index_d   = index_q;
    partial_d = partial_q;
    if (write_i) begin
      index_d = index_q + 2'd1;
      if (index_q != LAST_LANE) partial_d[index_q*LANE_W +: LANE_W] = data_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      index_q   <= '0;
      partial_q <= '0;
    end else begin
      index_q   <= index_d;
      partial_q <= partial_d;
    end
  end

  assign word_valid_o = write_i && (index_q == LAST_LANE);
  assign word_data_o  = {data_i, partial_q};
  assign index_d_o    = index_d;

endmodule

// File: rtl/fifo_8_to_32.sv
// SiTCP RX byte stream packed into 32-bit words and buffered in a FWFT word FIFO,
// with a saturating stored-byte count for TCP_RX_WC flow control.
module fifo_8_to_32 #(
  parameter int DEPTH = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WRITE,
  input  logic [7:0]  DATA_IN,
  input  logic        READ,
  output logic [31:0] DATA_OUT,
  output logic        EMPTY,
  output logic        FULL,
  output logic [15:0] RX_WC,
  output logic        OVERFLOW
);

  localparam int AW = $clog2(DEPTH);

  logic        word_valid;
  logic [31:0] word_data;
  logic [1:0]  index_d;

  byte_packer u_packer (
    .clk_i        (CLK),
    .rst_i        (RST),
    .write_i      (WRITE),
    .data_i       (DATA_IN),
    .word_valid_o (word_valid),
    .word_data_o  (word_data),
    .index_d_o    (index_d)
  );

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, full_q, overflow_q;
  logic [15:0]   rx_wc_q, rx_wc_d;
  logic [31:0]   head_q, head_d;
  logic [31:0]   byte_cnt;
  logic          push, pop;

  // A full FIFO still accepts a word when the same cycle pops a slot free.
  assign pop  = READ && !empty_q;
  assign push = word_valid && (!full_q || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    byte_cnt = 32'(count_d) * 32'd4 + 32'(index_d);
    rx_wc_d  = (byte_cnt > 32'h0000_FFFF) ? 16'hFFFF : byte_cnt[15:0];
    // Bypass the RAM when the next head is the word being written this cycle.
    head_d   = (push && (wr_ptr_q == rd_ptr_d)) ? word_data : mem[rd_ptr_d];
  end

  // NOTE: the storage array has no reset; only control state and the head register are cleared.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= word_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      rx_wc_q    <= '0;
      head_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == (AW+1)'(DEPTH));
      overflow_q <= overflow_q | (word_valid && !push);
      rx_wc_q    <= rx_wc_d;
      head_q     <= head_d;
    end
  end

  assign DATA_OUT = empty_q ? 32'h0 : head_q;
  assign EMPTY    = empty_q;
  assign FULL     = full_q;
  assign RX_WC    = rx_wc_q;
  assign OVERFLOW = overflow_q;

endmodule

// File: tb/tb_fifo_8_to_32.sv
// Self-checking bench for fifo_8_to_32: queue-based reference model compared every
// cycle, plus directed literal checks and a randomized byte/read stream.
module tb_fifo_8_to_32;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        WRITE = 1'b0;
  logic [7:0]  DATA_IN = 8'h00;
  logic        READ = 1'b0;
  logic [31:0] DATA_OUT;
  logic        EMPTY, FULL, OVERFLOW;
  logic [15:0] RX_WC;

  fifo_8_to_32 #(.DEPTH(DEPTH)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .WRITE    (WRITE),
    .DATA_IN  (DATA_IN),
    .READ     (READ),
    .DATA_OUT (DATA_OUT),
    .EMPTY    (EMPTY),
    .FULL     (FULL),
    .RX_WC    (RX_WC),
    .OVERFLOW (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
  endtask

  // Reference model: stored words, bytes of the word in progress, sticky overflow.
  logic [31:0] m_words[$];
  logic [7:0]  m_bytes[$];
  logic        m_ovf = 1'b0;

  task automatic model_step();
    automatic bit do_pop  = READ && (m_words.size() > 0);
    automatic bit new_word = WRITE && (m_bytes.size() == 3);
    automatic bit accept  = new_word && ((m_words.size() < DEPTH) || do_pop);
    automatic logic [31:0] w = 32'h0;
    if (new_word) w = {DATA_IN, m_bytes[2], m_bytes[1], m_bytes[0]};
    if (new_word && !accept) m_ovf <= 1'b1;
    if (do_pop) void'(m_words.pop_front());
    if (accept) m_words.push_back(w);
    if (WRITE) begin
      if (m_bytes.size() == 3) m_bytes.delete();
      else m_bytes.push_back(DATA_IN);
    end
  endtask

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_words.delete();
      m_bytes.delete();
      m_ovf <= 1'b0;
    end else begin
      model_step();
    end
  end

  function automatic logic [15:0] exp_wc();
    automatic int n = 4 * m_words.size() + m_bytes.size();
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  always @(negedge CLK) begin
    if (check_en) begin
      check("model_empty", {31'b0, EMPTY},    {31'b0, m_words.size() == 0});
      check("model_full",  {31'b0, FULL},     {31'b0, m_words.size() == DEPTH});
      check("model_data",  DATA_OUT,          (m_words.size() == 0) ? 32'h0 : m_words[0]);
      check("model_rx_wc", {16'b0, RX_WC},    {16'b0, exp_wc()});
      check("model_ovf",   {31'b0, OVERFLOW}, {31'b0, m_ovf});
    end
  end

  task automatic cycle(input logic w, input logic [7:0] d, input logic r);
    WRITE   = w;
    DATA_IN = d;
    READ    = r;
    @(posedge CLK);
    #1;
    WRITE = 1'b0;
    READ  = 1'b0;
  endtask

  task automatic do_reset();
    WRITE = 1'b0;
    READ  = 1'b0;
    RST   = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  function automatic logic [31:0] seq_word(input int k);
    automatic logic [7:0] b = 8'(4 * k + 1);
    return {8'(b + 8'd3), 8'(b + 8'd2), 8'(b + 8'd1), b};
  endfunction

  initial begin
    int wp, rp;
    #1 RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_empty",    {31'b0, EMPTY},    32'd1);
    check("rst_full",     {31'b0, FULL},     32'd0);
    check("rst_rx_wc",    {16'b0, RX_WC},    32'd0);
    check("rst_overflow", {31'b0, OVERFLOW}, 32'd0);
    check("rst_data",     DATA_OUT,          32'h0);
    check_en = 1'b1;
    RST = 1'b0;

    // Single word packing and pop.
    cycle(1'b1, 8'h11, 1'b0); check("pack_wc1", {16'b0, RX_WC}, 32'd1);
    cycle(1'b1, 8'h22, 1'b0); check("pack_wc2", {16'b0, RX_WC}, 32'd2);
    cycle(1'b1, 8'h33, 1'b0); check("pack_wc3", {16'b0, RX_WC}, 32'd3);
    check("pack_still_empty", {31'b0, EMPTY}, 32'd1);
    cycle(1'b1, 8'h44, 1'b0);
    check("pack_wc4",   {16'b0, RX_WC}, 32'd4);
    check("pack_empty", {31'b0, EMPTY}, 32'd0);
    check("pack_data",  DATA_OUT,       32'h44332211);
    cycle(1'b0, 8'h00, 1'b1);
    check("pop_empty", {31'b0, EMPTY}, 32'd1);
    check("pop_wc",    {16'b0, RX_WC}, 32'd0);

    // Fill past DEPTH words: fifth word is dropped.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 8'(i + 1), 1'b0);
      if (i == 15) begin
        check("fill_full", {31'b0, FULL},  32'd1);
        check("fill_wc16", {16'b0, RX_WC}, 32'd16);
      end
    end
    check("drop_overflow", {31'b0, OVERFLOW}, 32'd1);
    check("drop_wc",       {16'b0, RX_WC},    32'd16);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain_word%0d", k), DATA_OUT, seq_word(k));
      cycle(1'b0, 8'h00, 1'b1);
    end
    check("drain_empty", {31'b0, EMPTY}, 32'd1);

    // Full FIFO with READ on the completing byte accepts the word.
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i + 1), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
    cycle(1'b1, 8'hC3, 1'b1);
    check("fullrd_full", {31'b0, FULL},     32'd1);
    check("fullrd_ovf",  {31'b0, OVERFLOW}, 32'd0);
    check("fullrd_head", DATA_OUT,          32'h08070605);
    check("fullrd_wc",   {16'b0, RX_WC},    32'd16);
    for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b1);
    check("fullrd_last", DATA_OUT, 32'hC3C2C1C0);

    // Reset mid-word discards the partial bytes.
    do_reset();
    cycle(1'b1, 8'h55, 1'b0);
    cycle(1'b1, 8'h66, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0);
    check("rstmid_data", DATA_OUT,       32'hA3A2A1A0);
    check("rstmid_wc",   {16'b0, RX_WC}, 32'd4);
    cycle(1'b0, 8'h00, 1'b1);

    // Random stream with phases that bias the FIFO towards full or empty.
    do_reset();
    wp = 50;
    rp = 50;
    for (int c = 0; c < 10000; c++) begin
      if (c % 500 == 0) begin
        wp = $urandom_range(10, 95);
        rp = $urandom_range(2, 60);
      end
      cycle($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp);
    end

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
